// File: rtl/mtimer_pkg.sv
// Shared types and reset constants for the machine timer.
package mtimer_pkg;

    // Register slots. The numbering doubles as the index into the
    // per-register word arrays in the top level.
    typedef enum logic [2:0] {
        REG_MTIME_LO = 3'd0,
        REG_MTIME_HI = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_CTRL     = 3'd4,
        REG_PRESCALE = 3'd5,
        REG_NONE     = 3'd6
    } mtimer_reg_e;

    localparam int unsigned NUM_REGS = 6;

    localparam logic [63:0] MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/mtimer.vh
// Register offsets and CTRL bit positions for the machine timer.
`ifndef MTIMER_VH
`define MTIMER_VH

`define MTIMER_OFF_MTIME_LO 'h00
`define MTIMER_OFF_MTIME_HI 'h04
`define MTIMER_OFF_CMP_LO   'h08
`define MTIMER_OFF_CMP_HI   'h0C
`define MTIMER_OFF_CTRL     'h10
`define MTIMER_OFF_PRESCALE 'h14

`define MTIMER_CTRL_EN 0
`define MTIMER_CTRL_IE 1

`endif

// File: rtl/mtimer_byte_merge.sv
// Strobed byte-lane merge: lanes with strb set take new_word, others keep old_word.
module mtimer_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  strb,
    output logic [31:0] merged
);

    // Per-lane select between old and new byte.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit mtimecmp,
// CTRL (EN/IE), PRESCALE, and a registered level interrupt.
`include "mtimer.vh"

module mtimer
    import mtimer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wenable,
    output logic [31:0]           rdata,
    output logic                  irq
);

    logic [63:0]               mtime_q, mtime_d;
    logic [63:0]               cmp_q, cmp_d;
    logic                      en_q, en_d;
    logic                      ie_q, ie_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                      irq_q, irq_d;

    logic [ADDR_WIDTH-1:0]     word_addr;
    mtimer_reg_e               reg_sel;
    logic                      wr;
    logic                      tick;
    logic [31:0]               ctrl_word;

    // Current register words, strobes and merged write results, one slot per register.
    logic [NUM_REGS-1:0][31:0] old_w;
    logic [NUM_REGS-1:0][3:0]  strb_w;
    logic [NUM_REGS-1:0][31:0] merged_w;

    assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign wr        = sel && (wenable != 4'b0000);
    assign tick      = en_q && (pcnt_q == prescale_q);

    // Address decode to a register slot; anything else is unmapped.
    always_comb begin
        reg_sel = REG_NONE;
        if      (word_addr == ADDR_WIDTH'(`MTIMER_OFF_MTIME_LO)) reg_sel = REG_MTIME_LO;
        else if (word_addr == ADDR_WIDTH'(`MTIMER_OFF_MTIME_HI)) reg_sel = REG_MTIME_HI;
        else if (word_addr == ADDR_WIDTH'(`MTIMER_OFF_CMP_LO))   reg_sel = REG_CMP_LO;
        else if (word_addr == ADDR_WIDTH'(`MTIMER_OFF_CMP_HI))   reg_sel = REG_CMP_HI;
        else if (word_addr == ADDR_WIDTH'(`MTIMER_OFF_CTRL))     reg_sel = REG_CTRL;
        else if (word_addr == ADDR_WIDTH'(`MTIMER_OFF_PRESCALE)) reg_sel = REG_PRESCALE;
    end

    // Assemble readable words and gate write strobes to the addressed slot only.
    always_comb begin
        ctrl_word                  = 32'h0;
        ctrl_word[`MTIMER_CTRL_EN] = en_q;
        ctrl_word[`MTIMER_CTRL_IE] = ie_q;
        old_w[REG_MTIME_LO] = mtime_q[31:0];
        old_w[REG_MTIME_HI] = mtime_q[63:32];
        old_w[REG_CMP_LO]   = cmp_q[31:0];
        old_w[REG_CMP_HI]   = cmp_q[63:32];
        old_w[REG_CTRL]     = ctrl_word;
        old_w[REG_PRESCALE] = 32'(prescale_q);
        for (int i = 0; i < NUM_REGS; i++) begin
            strb_w[i] = (wr && (reg_sel == mtimer_reg_e'(i))) ? wenable : 4'b0000;
        end
    end

    // Unselected slots see a zero strobe, so their merged word is the old word.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_merge
        mtimer_byte_merge u_merge (
            .old_word (old_w[g]),
            .new_word (wdata),
            .strb     (strb_w[g]),
            .merged   (merged_w[g])
        );
    end

    // Reads have no side effects; sel=0 or unmapped offsets return zero.
    always_comb begin
        rdata = 32'h0;
        if (sel && (reg_sel != REG_NONE)) rdata = old_w[reg_sel];
    end

    // Next-state: bus writes to mtime beat the tick, PRESCALE writes restart the prescaler.
    always_comb begin
        mtime_d    = mtime_q;
        cmp_d      = {merged_w[REG_CMP_HI], merged_w[REG_CMP_LO]};
        en_d       = merged_w[REG_CTRL][`MTIMER_CTRL_EN];
        ie_d       = merged_w[REG_CTRL][`MTIMER_CTRL_IE];
        prescale_d = merged_w[REG_PRESCALE][PRESCALE_WIDTH-1:0];
        pcnt_d     = pcnt_q;
        irq_d      = ie_q && (mtime_q >= cmp_q);

        if ((strb_w[REG_MTIME_LO] != 4'b0000) || (strb_w[REG_MTIME_HI] != 4'b0000))
            mtime_d = {merged_w[REG_MTIME_HI], merged_w[REG_MTIME_LO]};
        else if (tick)
            mtime_d = mtime_q + 64'd1;

        if (strb_w[REG_PRESCALE] != 4'b0000)
            pcnt_d = '0;
        else if (en_q)
            pcnt_d = tick ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q    <= MTIME_RST;
            cmp_q      <= MTIMECMP_RST;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    // Byte offset bits and reserved register bits carry no state.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], merged_w[REG_CTRL][31:2],
                           merged_w[REG_PRESCALE][31:PRESCALE_WIDTH]};

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: directed scenarios plus random bus traffic against a
// cycle-level reference model of the timer's register rules.
module tb_mtimer;

    localparam int AW = 5;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wenable = '0;
    logic [31:0]   rdata;
    logic          irq;

    mtimer #(.ADDR_WIDTH(AW), .PRESCALE_WIDTH(PW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .addr    (addr),
        .wdata   (wdata),
        .wenable (wenable),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [63:0]   m_time, m_cmp;
    logic          m_en, m_ie, m_irq;
    logic [PW-1:0] m_pre, m_pcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        case (int'(a) / 4)
            0:       return m_time[31:0];
            1:       return m_time[63:32];
            2:       return m_cmp[31:0];
            3:       return m_cmp[63:32];
            4:       return {30'b0, m_ie, m_en};
            5:       return 32'(m_pre);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_time = 64'h0;
        m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en   = 1'b0;
        m_ie   = 1'b0;
        m_pre  = '0;
        m_pcnt = '0;
        m_irq  = 1'b0;
    endtask

    // One clock edge of the timer, from pre-edge model state and bus inputs.
    task automatic model_edge(input logic r, input logic s, input logic [AW-1:0] a,
                              input logic [31:0] wd, input logic [3:0] we);
        logic        tk;
        logic [63:0] nt;
        logic [31:0] t;
        if (!r) begin
            model_reset();
            return;
        end
        tk    = m_en && (m_pcnt == m_pre);
        m_irq = m_ie && (m_time >= m_cmp);
        nt    = tk ? m_time + 64'd1 : m_time;
        if (m_en) m_pcnt = tk ? '0 : m_pcnt + 1'b1;
        if (s && we != 4'b0) begin
            case (int'(a) / 4)
                0: nt = {m_time[63:32], lanes(m_time[31:0], wd, we)};
                1: nt = {lanes(m_time[63:32], wd, we), m_time[31:0]};
                2: m_cmp[31:0]  = lanes(m_cmp[31:0], wd, we);
                3: m_cmp[63:32] = lanes(m_cmp[63:32], wd, we);
                4: begin
                    t    = lanes({30'b0, m_ie, m_en}, wd, we);
                    m_en = t[0];
                    m_ie = t[1];
                end
                5: begin
                    t      = lanes(32'(m_pre), wd, we);
                    m_pre  = t[PW-1:0];
                    m_pcnt = '0;
                end
                default: ;
            endcase
        end
        m_time = nt;
    endtask

    // One bus cycle: drive after negedge, check rdata, clock, check irq.
    task automatic cyc(input logic r, input logic s, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [3:0] we, output logic [31:0] rd_o);
        @(negedge clk);
        rst_n = r; sel = s; addr = a; wdata = wd; wenable = we;
        #1;
        rd_o = rdata;
        check("rdata", rdata, s ? m_read(a) : 32'h0);
        @(posedge clk);
        model_edge(r, s, a, wd, we);
        #1;
        check("irq", irq, m_irq);
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 32'h0, 4'h0, d);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] x;
        cyc(1'b1, 1'b1, a, d, we, x);
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] v);
        cyc(1'b1, 1'b1, a, 32'h0, 4'h0, v);
    endtask

    initial begin
        logic [31:0] v, exp;
        logic [AW-1:0] ra;
        logic [31:0]   rw;
        logic [3:0]    rwe;
        logic          rr, rs;

        // Bring-up reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // 1. Reset values and sel=0 reads
        rd(5'h00, v); check("rst_mtime_lo", v, 32'h0);
        rd(5'h04, v); check("rst_mtime_hi", v, 32'h0);
        rd(5'h08, v); check("rst_cmp_lo", v, 32'hFFFF_FFFF);
        rd(5'h0C, v); check("rst_cmp_hi", v, 32'hFFFF_FFFF);
        rd(5'h10, v); check("rst_ctrl", v, 32'h0);
        rd(5'h14, v); check("rst_prescale", v, 32'h0);
        rd(5'h18, v); check("rst_unmapped", v, 32'h0);
        check("rst_irq", irq, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, AW'(i * 4), 32'h0, 4'h0, v);
            check("nosel_rdata", v, 32'h0);
        end

        // 2. Prescale 3: one tick every 4 cycles, then freeze
        wr(5'h14, 32'd3, 4'hF);
        wr(5'h10, 32'h1, 4'hF);
        idle(20);
        rd(5'h00, v); check("presc_mtime", v, 32'd5);
        wr(5'h10, 32'h0, 4'hF);
        idle(8);
        rd(5'h00, v); check("frozen_mtime", v, 32'd5);

        // 3. Carry into HI, then 64-bit wrap
        wr(5'h14, 32'h0, 4'hF);
        wr(5'h00, 32'hFFFF_FFFE, 4'hF);
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h10, 32'h1, 4'hF);
        idle(2);
        rd(5'h00, v); check("carry_lo", v, 32'h0);
        rd(5'h04, v); check("carry_hi", v, 32'h1);
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h00, 32'hFFFF_FFFF, 4'hF);
        rd(5'h00, v); check("max_lo", v, 32'hFFFF_FFFF);
        rd(5'h00, v); check("wrap_lo", v, 32'h0);
        rd(5'h04, v); check("wrap_hi", v, 32'h0);

        // 4. Compare and interrupt timing
        wr(5'h10, 32'h0, 4'hF);
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, 32'd10, 4'hF);
        wr(5'h00, 32'h0, 4'hF);
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h10, 32'h3, 4'hF);
        idle(10);
        check("irq_before", irq, 1'b0);
        idle(1);
        check("irq_rise", irq, 1'b1);
        wr(5'h08, 32'd100, 4'hF);
        check("irq_at_cmp_wr", irq, 1'b1);
        idle(1);
        check("irq_drop", irq, 1'b0);
        wr(5'h10, 32'h1, 4'hF);
        wr(5'h08, 32'h0, 4'hF);
        idle(4);
        check("irq_ie0", irq, 1'b0);

        // 5. Partial-lane write coinciding with a tick; unmapped writes
        exp = {m_time[31:16], 8'h56, m_time[7:0]};
        wr(5'h00, 32'h1234_5678, 4'b0010);
        rd(5'h00, v); check("lane_write", v, exp);
        wr(5'h18, 32'hDEAD_BEEF, 4'hF);
        wr(5'h1C, 32'hCAFE_F00D, 4'hF);
        rd(5'h18, v); check("unmapped_18", v, 32'h0);
        rd(5'h1C, v); check("unmapped_1c", v, 32'h0);
        for (int i = 0; i < 6; i++) rd(AW'(i * 4), v);

        // Random bus traffic against the model
        for (int n = 0; n < 400; n++) begin
            rr  = ($urandom_range(0, 63) != 0);
            rs  = ($urandom_range(0, 3) != 0);
            ra  = AW'($urandom_range(0, 31));
            rw  = $urandom;
            rwe = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if (ra[AW-1:2] == 3'd5) rw = 32'($urandom_range(0, 3));
            if (ra[AW-1:2] == 3'd3 || ra[AW-1:2] == 3'd1) rw = 32'($urandom_range(0, 1));
            if (ra[AW-1:2] == 3'd2) rw = 32'($urandom_range(0, 400));
            cyc(rr, rs, ra, rw, rwe, v);
        end

        // 6. Reset while counting with irq high
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, 32'h0, 4'hF);
        wr(5'h14, 32'h0, 4'hF);
        wr(5'h10, 32'h3, 4'hF);
        idle(3);
        check("irq_pre_rst", irq, 1'b1);
        cyc(1'b0, 1'b1, 5'h08, 32'h55, 4'hF, v);
        check("irq_post_rst", irq, 1'b0);
        rd(5'h08, v); check("post_rst_cmp_lo", v, 32'hFFFF_FFFF);
        rd(5'h10, v); check("post_rst_ctrl", v, 32'h0);
        rd(5'h14, v); check("post_rst_prescale", v, 32'h0);
        idle(5);
        rd(5'h00, v); check("post_rst_mtime_lo", v, 32'h0);
        rd(5'h04, v); check("post_rst_mtime_hi", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
